// File: rtl/core_ctrl_pkg.sv
// Shared core definitions: controller state encoding, RV32I major opcodes and
// the execute-stage opcode classifier used by the control FSM.
package core_ctrl_pkg;

  localparam logic [2:0] F_SETUP  = 3'd0;
  localparam logic [2:0] F_ACCESS = 3'd1;
  localparam logic [2:0] EXEC     = 3'd2;
  localparam logic [2:0] M_SETUP  = 3'd3;
  localparam logic [2:0] M_ACCESS = 3'd4;
  localparam logic [2:0] T_SETUP  = 3'd5;
  localparam logic [2:0] T_ACCESS = 3'd6;
  localparam logic [2:0] T_PC     = 3'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    EX_ALU,
    EX_JALR,
    EX_BRANCH,
    EX_MEM,
    EX_TRAP
  } exec_class_e;

  // SYSTEM and every opcode not handled in EXEC fall through to the trap path.
  function automatic exec_class_e exec_class(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM:   return EX_ALU;
      OPC_JALR:             return EX_JALR;
      OPC_BRANCH:           return EX_BRANCH;
      OPC_LOAD, OPC_STORE:  return EX_MEM;
      default:              return EX_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/core_ctrl_apb_phase.sv
// APB phase generator: turns the controller's setup/access phase into
// psel/penable and reports when the access phase may retire.
module apb_phase (
  input  logic rst,
  input  logic setup,
  input  logic access,
  input  logic pready,
  output logic psel,
  output logic penable,
  output logic done
);

  // psel is suppressed combinationally so it drops the moment rst rises.
  assign psel    = !rst && (setup || access);
  assign penable = !rst && access;
  assign done    = access && pready;

endmodule

// File: rtl/core_ctrl.sv
// Multicycle RV32I control FSM: fetch, execute, memory access and trap entry
// over an APB master port, decoding all datapath controls from the state.
module core_ctrl
  import core_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] odata_op,
  input  logic [6:0] ir_op,
  input  logic       branch_taken,
  input  logic       pready,
  input  logic       pslverr,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic       wa_mux,
  output logic       mem_access,
  output logic       microop_pc_zero,
  output logic       sys_load,
  output logic       lui_flag,
  output logic       jal_flag,
  output logic       sys_load_pc,
  output logic       mem_access_rdy,
  output logic       store_alu,
  output logic       load_branch,
  output logic       load_jalr,
  output logic       load_pc,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       trap
);

  logic [2:0] state, state_nxt;
  logic       setup, access, done;

  assign setup  = (state == F_SETUP)  || (state == M_SETUP)  || (state == T_SETUP);
  assign access = (state == F_ACCESS) || (state == M_ACCESS) || (state == T_ACCESS);

  apb_phase u_apb_phase (
    .rst     (rst),
    .setup   (setup),
    .access  (access),
    .pready  (pready),
    .psel    (psel),
    .penable (penable),
    .done    (done)
  );

  // NOTE: non-blocking assignment keeps the register update race-free against other clocked readers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F_SETUP;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default here so no path through the case infers a latch.
    state_nxt       = state;
    pwrite          = 1'b0;
    wa_mux          = 1'b0;
    mem_access      = 1'b0;
    microop_pc_zero = 1'b0;
    sys_load        = 1'b0;
    lui_flag        = 1'b0;
    jal_flag        = 1'b0;
    sys_load_pc     = 1'b0;
    mem_access_rdy  = 1'b0;
    store_alu       = 1'b0;
    load_branch     = 1'b0;
    load_jalr       = 1'b0;
    load_pc         = 1'b0;
    ir_we           = 1'b0;
    pc_we           = 1'b0;
    reg_we          = 1'b0;
    trap            = 1'b0;

    case (state)
      F_SETUP: begin
        microop_pc_zero = 1'b1;
        pc_we           = 1'b1;
        state_nxt       = F_ACCESS;
      end
      F_ACCESS: begin
        microop_pc_zero = 1'b1;
        if (done) begin
          if (pslverr) begin
            state_nxt = T_SETUP;
          end else if (odata_op == OPC_JAL) begin
            // jal_flag takes over as the sole PC source in the completing cycle.
            microop_pc_zero = 1'b0;
            jal_flag        = 1'b1;
            wa_mux          = 1'b1;
            pc_we           = 1'b1;
            reg_we          = 1'b1;
            state_nxt       = F_SETUP;
          end else if (odata_op == OPC_LUI || odata_op == OPC_AUIPC) begin
            lui_flag  = 1'b1;
            wa_mux    = 1'b1;
            reg_we    = 1'b1;
            state_nxt = F_SETUP;
          end else begin
            ir_we     = 1'b1;
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        state_nxt = F_SETUP;
        case (exec_class(ir_op))
          EX_ALU: begin
            store_alu = 1'b1;
            reg_we    = 1'b1;
          end
          EX_JALR: begin
            load_jalr = 1'b1;
            pc_we     = 1'b1;
            load_pc   = 1'b1;
            reg_we    = 1'b1;
          end
          EX_BRANCH: begin
            load_branch = 1'b1;
            pc_we       = branch_taken;
          end
          EX_MEM:  state_nxt = M_SETUP;
          default: state_nxt = T_SETUP;
        endcase
      end
      M_SETUP, M_ACCESS: begin
        mem_access = 1'b1;
        pwrite     = (ir_op == OPC_STORE);
        if (state == M_SETUP) begin
          state_nxt = M_ACCESS;
        end else if (done) begin
          if (pslverr) begin
            state_nxt = T_SETUP;
          end else begin
            mem_access_rdy = (ir_op == OPC_LOAD);
            reg_we         = (ir_op == OPC_LOAD);
            state_nxt      = F_SETUP;
          end
        end
      end
      T_SETUP, T_ACCESS: begin
        pwrite   = 1'b1;
        sys_load = 1'b1;
        if (state == T_SETUP) begin
          state_nxt = T_ACCESS;
        end else if (done) begin
          ir_we     = 1'b1;
          state_nxt = T_PC;
        end
      end
      T_PC: begin
        sys_load_pc = 1'b1;
        pc_we       = 1'b1;
        trap        = 1'b1;
        state_nxt   = F_SETUP;
      end
      default: state_nxt = F_SETUP;
    endcase
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: a transaction-level model expands each
// instruction into expected per-cycle controls; a monitor compares them.
module tb_core_ctrl;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef struct packed {
    logic psel, penable, pwrite, wa_mux, mem_access, microop_pc_zero, sys_load;
    logic lui_flag, jal_flag, sys_load_pc, mem_access_rdy, store_alu;
    logic load_branch, load_jalr, load_pc, ir_we, pc_we, reg_we, trap;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] odata_op = '0;
  logic [6:0] ir_op = '0;
  logic       branch_taken = 1'b0, pready = 1'b0, pslverr = 1'b0;
  logic psel, penable, pwrite, wa_mux, mem_access, microop_pc_zero, sys_load;
  logic lui_flag, jal_flag, sys_load_pc, mem_access_rdy, store_alu;
  logic load_branch, load_jalr, load_pc, ir_we, pc_we, reg_we, trap;

  outs_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  core_ctrl dut (
    .clk(clk), .rst(rst), .odata_op(odata_op), .ir_op(ir_op),
    .branch_taken(branch_taken), .pready(pready), .pslverr(pslverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .wa_mux(wa_mux),
    .mem_access(mem_access), .microop_pc_zero(microop_pc_zero),
    .sys_load(sys_load), .lui_flag(lui_flag), .jal_flag(jal_flag),
    .sys_load_pc(sys_load_pc), .mem_access_rdy(mem_access_rdy),
    .store_alu(store_alu), .load_branch(load_branch), .load_jalr(load_jalr),
    .load_pc(load_pc), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .trap(trap)
  );

  always #5 clk = ~clk;

  function automatic outs_t actual();
    return '{psel, penable, pwrite, wa_mux, mem_access, microop_pc_zero, sys_load,
             lui_flag, jal_flag, sys_load_pc, mem_access_rdy, store_alu,
             load_branch, load_jalr, load_pc, ir_we, pc_we, reg_we, trap};
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      e = exp_q.pop_front();
      check("ctrl_outs", 32'(actual()), 32'(e));
    end
  end

  task automatic step(input logic [6:0] od, input logic rdy, input logic err,
                      input logic bt, input outs_t e);
    odata_op     = od;
    pready       = rdy;
    pslverr      = err;
    branch_taken = bt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t reset_view();
    outs_t e = '0;
    e.microop_pc_zero = 1'b1;
    e.pc_we           = 1'b1;
    return e;
  endfunction

  // Trap entry: write PC to address 4 (pslverr ignored), read back vector, load PC.
  task automatic do_trap(input int twait, input logic terr);
    outs_t e = '0;
    ir_op = r7();
    e.psel = 1'b1; e.pwrite = 1'b1; e.sys_load = 1'b1;
    step(r7(), r1(), r1(), r1(), e);
    e.penable = 1'b1;
    for (int i = 0; i < twait; i++) step(r7(), 1'b0, r1(), r1(), e);
    e.ir_we = 1'b1;
    step(r7(), 1'b1, terr, r1(), e);
    e = '0;
    e.sys_load_pc = 1'b1; e.pc_we = 1'b1; e.trap = 1'b1;
    step(r7(), r1(), r1(), r1(), e);
  endtask

  task automatic run_insn(input logic [6:0] op, input int fwait, input logic ferr,
                          input int mwait, input logic merr, input logic bt,
                          input int twait, input logic terr);
    outs_t e = '0;
    ir_op = r7();
    e.psel = 1'b1; e.microop_pc_zero = 1'b1; e.pc_we = 1'b1;
    step(r7(), r1(), r1(), r1(), e);
    e.pc_we = 1'b0; e.penable = 1'b1;
    for (int i = 0; i < fwait; i++) step(r7(), 1'b0, r1(), r1(), e);
    if (ferr) begin
      step(op, 1'b1, 1'b1, r1(), e);
      do_trap(twait, terr);
      return;
    end
    if (op == JAL) begin
      e.microop_pc_zero = 1'b0;
      e.jal_flag = 1'b1; e.wa_mux = 1'b1; e.pc_we = 1'b1; e.reg_we = 1'b1;
      step(op, 1'b1, 1'b0, r1(), e);
      return;
    end
    if (op == LUI || op == AUIPC) begin
      e.lui_flag = 1'b1; e.wa_mux = 1'b1; e.reg_we = 1'b1;
      step(op, 1'b1, 1'b0, r1(), e);
      return;
    end
    e.ir_we = 1'b1;
    step(op, 1'b1, 1'b0, r1(), e);
    ir_op = op;
    e = '0;
    if (op == OPR || op == OPIMM) begin
      e.store_alu = 1'b1; e.reg_we = 1'b1;
      step(r7(), r1(), r1(), bt, e);
    end else if (op == JALR) begin
      e.load_jalr = 1'b1; e.pc_we = 1'b1; e.load_pc = 1'b1; e.reg_we = 1'b1;
      step(r7(), r1(), r1(), bt, e);
    end else if (op == BRANCH) begin
      e.load_branch = 1'b1; e.pc_we = bt;
      step(r7(), r1(), r1(), bt, e);
    end else if (op == LOAD || op == STORE) begin
      step(r7(), r1(), r1(), bt, e);
      e.psel = 1'b1; e.mem_access = 1'b1; e.pwrite = (op == STORE);
      step(r7(), r1(), r1(), r1(), e);
      e.penable = 1'b1;
      for (int i = 0; i < mwait; i++) step(r7(), 1'b0, r1(), r1(), e);
      if (op == LOAD && !merr) begin
        e.mem_access_rdy = 1'b1; e.reg_we = 1'b1;
      end
      step(r7(), 1'b1, merr, r1(), e);
      if (merr) do_trap(twait, terr);
    end else begin
      step(r7(), r1(), r1(), bt, e);
      do_trap(twait, terr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    outs_t e;
    logic [6:0] ops [10];
    ops = '{OPR, OPIMM, JALR, BRANCH, LOAD, STORE, JAL, LUI, AUIPC, SYSTEM};

    #2;
    check("reset_outs", 32'(actual()), 32'(reset_view()));
    check("reset_psel", 32'(psel), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed instructions: op, fwait, ferr, mwait, merr, bt, twait, terr.
    run_insn(OPIMM,  0, 0, 0, 0, 0, 0, 0);   // ADDI, 3 cycles
    run_insn(OPIMM,  0, 0, 0, 0, 1, 0, 0);
    run_insn(JAL,    2, 0, 0, 0, 0, 0, 0);
    run_insn(LOAD,   0, 0, 4, 0, 0, 0, 0);
    run_insn(LOAD,   1, 0, 4, 1, 0, 2, 0);   // bus error: no write, trap
    run_insn(BRANCH, 0, 0, 0, 0, 0, 0, 0);
    run_insn(BRANCH, 0, 0, 0, 0, 1, 0, 0);
    run_insn(SYSTEM, 0, 0, 0, 0, 0, 1, 1);   // ECALL, pslverr ignored in trap
    run_insn(STORE,  1, 0, 2, 0, 0, 0, 0);
    run_insn(STORE,  0, 0, 0, 1, 0, 0, 0);
    run_insn(JALR,   1, 0, 0, 0, 0, 0, 0);
    run_insn(LUI,    0, 0, 0, 0, 0, 0, 0);
    run_insn(AUIPC,  3, 0, 0, 0, 0, 0, 0);
    run_insn(JAL,    0, 1, 0, 0, 0, 0, 0);   // fetch error on JAL: no writes
    run_insn(7'h7f,  0, 0, 0, 0, 0, 0, 0);   // unlisted opcode traps

    // Reset asserted mid M_ACCESS must drop psel without a clock edge.
    e = '0; e.psel = 1'b1; e.microop_pc_zero = 1'b1; e.pc_we = 1'b1;
    step(r7(), 1'b0, 1'b0, 1'b0, e);
    e.pc_we = 1'b0; e.penable = 1'b1; e.ir_we = 1'b1;
    step(LOAD, 1'b1, 1'b0, 1'b0, e);
    ir_op = LOAD;
    e = '0;
    step(r7(), 1'b0, 1'b0, 1'b0, e);
    e.psel = 1'b1; e.mem_access = 1'b1;
    step(r7(), 1'b0, 1'b0, 1'b0, e);
    e.penable = 1'b1;
    odata_op = r7(); pready = 1'b0; pslverr = 1'b0;
    exp_q.push_back(e);
    #5;
    rst = 1'b1;
    #1;
    check("rst_async_psel", 32'(psel), 32'd0);
    check("rst_async_outs", 32'(actual()), 32'(reset_view()));
    @(posedge clk); #1;
    check("rst_hold_outs", 32'(actual()), 32'(reset_view()));
    rst = 1'b0;
    run_insn(OPR, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) == 0) ? r7() : ops[$urandom_range(0, 9)];
      run_insn(op, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
               $urandom_range(0, 3), $urandom_range(0, 5) == 0, r1(),
               $urandom_range(0, 2), r1());
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
